// File: rtl/uart_rcv_fifo.sv
// UART receiver with runtime frame configuration, mid-bit start validation,
// optional even/odd parity and a small receive FIFO popped by the bus side.
module uart_rcv_fifo #(
  parameter int MAX_DATA   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD_W   = 14
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          serial_in,
  input  logic [3:0]                    data_size,
  input  logic [PERIOD_W-1:0]           bit_period,
  input  logic [1:0]                    parity_mode,
  input  logic                          data_read,
  output logic [MAX_DATA-1:0]           rx_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_error,
  output logic                          framing_error,
  output logic                          parity_error
);

  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam int         CNT_W = PTR_W + 1;
  localparam logic [4:0] MAX_N = 5'(MAX_DATA);

  typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP, LOAD} state_t;

  // Data bits per frame limited to 5..MAX_DATA.
  function automatic logic [4:0] clamp_size(input logic [3:0] ds);
    logic [4:0] n;
    n = {1'b0, ds};
    if (n < 5'd5)       n = 5'd5;
    else if (n > MAX_N) n = MAX_N;
    return n;
  endfunction

  // Bit periods shorter than 4 clocks are stretched to 4 so the half-bit
  // offset is always at least 2.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] bp);
    logic [PERIOD_W-1:0] p;
    p = bp;
    if (bp < PERIOD_W'(4)) p = PERIOD_W'(4);
    return p;
  endfunction

  state_t                state, state_nxt;
  logic                  sync1, rx_s, rx_prev;
  logic [PERIOD_W-1:0]   cnt, bp_lat, bp_in;
  logic [4:0]            bit_idx, n_lat;
  logic                  par_en, par_odd;
  logic [MAX_DATA-1:0]   shift;
  logic                  par_acc, stop_bit;
  logic [MAX_DATA-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  logic start_evt, tick, last_bit, sampling, load;
  logic par_fail, frame_ok, full, push, pop;

  assign bp_in     = clamp_period(bit_period);
  assign start_evt = (state == IDLE) && !rx_s && rx_prev;
  assign tick      = (cnt == '0);
  assign last_bit  = (bit_idx == n_lat - 5'd1);
  assign sampling  = (state inside {START_CHK, DATA, PARITY, STOP});
  assign load      = (state == LOAD);
  assign par_fail  = par_en && (par_acc != par_odd);
  assign frame_ok  = stop_bit && !par_fail;
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop       = data_read && (fifo_count != '0);
  assign push      = load && frame_ok && (!full || pop);

  assign data_ready = (fifo_count != '0);
  assign rx_data    = data_ready ? mem[rd_ptr] : '0;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= serial_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; every sampling state advances only on a counter tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_evt) state_nxt = START_CHK;
      START_CHK: if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && last_bit) state_nxt = par_en ? PARITY : STOP;
      PARITY:    if (tick) state_nxt = STOP;
      STOP:      if (tick) state_nxt = LOAD;
      LOAD:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Frame configuration latch, bit-time counter and data bit index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt     <= '0;
      bp_lat  <= PERIOD_W'(4);
      n_lat   <= 5'd5;
      bit_idx <= '0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
    end else if (start_evt) begin
      n_lat   <= clamp_size(data_size);
      bp_lat  <= bp_in;
      par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_odd <= (parity_mode == 2'b10);
      cnt     <= (bp_in >> 1) - PERIOD_W'(1);
      bit_idx <= '0;
    end else if (sampling) begin
      if (tick) cnt <= bp_lat - PERIOD_W'(1);
      else      cnt <= cnt - PERIOD_W'(1);
      if (state == DATA && tick) bit_idx <= bit_idx + 5'd1;
    end
  end

  // Sampled frame contents: data LSB first, running parity, stop bit.
  always_ff @(posedge clk) begin
    if (start_evt) begin
      shift   <= '0;
      par_acc <= 1'b0;
    end else if (tick) begin
      case (state)
        DATA: begin
          shift   <= shift | (MAX_DATA'(rx_s) << bit_idx);
          par_acc <= par_acc ^ rx_s;
        end
        PARITY:  par_acc  <= par_acc ^ rx_s;
        STOP:    stop_bit <= rx_s;
        default: ;
      endcase
    end
  end

  // FIFO storage; only the head entry is ever visible on rx_data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Status flags: frame errors reflect the last completed frame, overrun is sticky until a pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (load) begin
        framing_error <= !stop_bit;
        parity_error  <= par_fail;
      end
      if (load && frame_ok && full && !pop) overrun_error <= 1'b1;
      else if (pop)                         overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Bench for uart_rcv_fifo: directed frames, expected words queued at issue
// time and compared by a monitor whenever an entry is popped.
module tb_uart_rcv_fifo;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        serial_in = 1'b1;
  logic [3:0]  data_size = 4'd8;
  logic [13:0] bit_period = 14'd10;
  logic [1:0]  parity_mode = 2'b00;
  logic        data_read = 1'b0;
  logic [7:0]  rx_data;
  logic        data_ready;
  logic [2:0]  fifo_count;
  logic        overrun_error, framing_error, parity_error;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         start_cyc = 0;
  logic       dr_prev = 1'b0;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  uart_rcv_fifo #(.MAX_DATA(8), .FIFO_DEPTH(4), .PERIOD_W(14)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_size(data_size),
    .bit_period(bit_period), .parity_mode(parity_mode), .data_read(data_read),
    .rx_data(rx_data), .data_ready(data_ready), .fifo_count(fifo_count),
    .overrun_error(overrun_error), .framing_error(framing_error),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records data_ready rise time and checks every popped word.
  always @(negedge clk) begin
    if (data_ready && !dr_prev) rise_cyc = cyc;
    dr_prev = data_ready;
    if (n_rst && data_read && data_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, expected no entry", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %h, expected %h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [15:0] d, input int n, input int bp,
                            input bit use_par, input bit par_bit, input bit stop);
    serial_in = 1'b0;
    tick(bp);
    for (int i = 0; i < n; i++) begin
      serial_in = d[i];
      tick(bp);
    end
    if (use_par) begin
      serial_in = par_bit;
      tick(bp);
    end
    serial_in = stop;
    tick(bp);
    serial_in = 1'b1;
    tick(4);
  endtask

  task automatic pop_one();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_overrun"}, overrun_error, 0);
    check({tag, "_framing"}, framing_error, 0);
    check({tag, "_parity"}, parity_error, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    tick(3);
    check_all_zero("reset");
    n_rst = 1'b1;
    tick(3);

    // Basic 8N1 frame, latency from start-bit drive to data_ready = 3 + 96
    data_size = 4'd8; bit_period = 14'd10; parity_mode = 2'b00;
    exp_q.push_back(8'hA5);
    start_cyc = cyc;
    send_frame(16'h00A5, 8, 10, 0, 0, 1);
    check("latency", rise_cyc - start_cyc, 99);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_count", fifo_count, 1);
    check("t1_overrun", overrun_error, 0);
    check("t1_framing", framing_error, 0);
    check("t1_parity", parity_error, 0);
    pop_one();
    check("t1_ready_after_pop", data_ready, 0);

    // 7 data bits, even parity: 0x35 has four ones so the parity bit is 0
    data_size = 4'd7; bit_period = 14'd16; parity_mode = 2'b01;
    exp_q.push_back(8'h35);
    send_frame(16'h0035, 7, 16, 1, 0, 1);
    check("t2_parity_ok", parity_error, 0);
    check("t2_count1", fifo_count, 1);
    send_frame(16'h0035, 7, 16, 1, 1, 1);
    check("t2_parity_bad", parity_error, 1);
    check("t2_count_still1", fifo_count, 1);
    check("t2_framing", framing_error, 0);
    pop_one();
    check("t2_count0", fifo_count, 0);

    // Framing error then a good frame that clears it
    data_size = 4'd8; bit_period = 14'd10; parity_mode = 2'b00;
    send_frame(16'h003C, 8, 10, 0, 0, 0);
    check("t3_framing_set", framing_error, 1);
    check("t3_parity_cleared", parity_error, 0);
    check("t3_count0", fifo_count, 0);
    exp_q.push_back(8'h11);
    send_frame(16'h0011, 8, 10, 0, 0, 1);
    check("t3_framing_clear", framing_error, 0);
    check("t3_count1", fifo_count, 1);
    pop_one();

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(16'(i), 8, 10, 0, 0, 1);
    end
    check("t4_count_full", fifo_count, 4);
    check("t4_overrun_set", overrun_error, 1);
    check("t4_head", rx_data, 8'h01);
    pop_one();
    check("t4_overrun_clear", overrun_error, 0);
    check("t4_count3", fifo_count, 3);
    exp_q.push_back(8'h06);
    send_frame(16'h0006, 8, 10, 0, 0, 1);
    check("t4_refull", fifo_count, 4);
    // LOAD of 0x07 lands at start+99; pop in that same cycle
    exp_q.push_back(8'h07);
    fork
      send_frame(16'h0007, 8, 10, 0, 0, 1);
      begin
        tick(98);
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
      end
    join
    check("t4_coincide_count", fifo_count, 4);
    check("t4_coincide_overrun", overrun_error, 0);
    check("t4_coincide_head", rx_data, 8'h03);
    repeat (4) pop_one();
    check("t4_drained", fifo_count, 0);

    // Short glitch must not change state or flags
    bit_period = 14'd20;
    exp_q.push_back(8'h42);
    send_frame(16'h0042, 8, 20, 0, 0, 1);
    send_frame(16'h00C7, 8, 20, 0, 0, 0);
    check("t5_pre_framing", framing_error, 1);
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(40);
    check("t5_count", fifo_count, 1);
    check("t5_framing_held", framing_error, 1);
    check("t5_parity_held", parity_error, 0);
    check("t5_overrun_held", overrun_error, 0);
    exp_q.push_back(8'h24);
    send_frame(16'h0024, 8, 20, 0, 0, 1);
    check("t5_recover_count", fifo_count, 2);
    check("t5_recover_framing", framing_error, 0);
    repeat (2) pop_one();

    // Reset in the middle of data bit 4
    bit_period = 14'd10;
    exp_q.push_back(8'h77);
    send_frame(16'h0077, 8, 10, 0, 0, 1);
    check("t6_pre_count", fifo_count, 1);
    fork
      send_frame(16'h00C3, 8, 10, 0, 0, 1);
      begin
        tick(55);
        n_rst = 1'b0;
        exp_q.delete();
        tick(2);
        check_all_zero("midreset");
      end
    join
    tick(2);
    n_rst = 1'b1;
    tick(3);
    check("t6_after_release", fifo_count, 0);
    exp_q.push_back(8'h5A);
    send_frame(16'h005A, 8, 10, 0, 0, 1);
    check("t6_count", fifo_count, 1);
    check("t6_head", rx_data, 8'h5A);
    pop_one();
    check("t6_count0", fifo_count, 0);

    // Read while empty is ignored
    pop_one();
    check("empty_read_count", fifo_count, 0);
    check("queue_consumed", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rcv_fifo.md
# uart_rcv_fifo

Parametrised UART receiver replacing the fixed 8-bit, single-buffer receive path. It adds a compile-time maximum data width, runtime-selectable even/odd parity checking, a mid-bit start-bit validation that rejects glitches, and a receive FIFO in place of the single data buffer. It sits between the raw `serial_in` pad input and the bus-side register file, which pops words with `data_read`.

## Interface
Parameters:
- `MAX_DATA`, 8: maximum data bits per frame and the width of `rx_data`; legal range 5..16.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2, at least 2.
- `PERIOD_W`, 14: width of `bit_period`.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `serial_in`  in  1  asynchronous line; idles high.
- `data_size`  in  4  data bits per frame.
- `bit_period`  in  PERIOD_W  clocks per bit.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `data_read`  in  1  single-cycle pop of the FIFO head.
- `rx_data`  out  MAX_DATA  FIFO head, right-justified, unused upper bits 0.
- `data_ready`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `overrun_error`  out  1  sticky; a good frame was dropped because the FIFO was full.
- `framing_error`  out  1  the last completed frame had stop bit = 0.
- `parity_error`  out  1  the last completed frame failed its parity check.

## Operation
- `serial_in` passes through a 2-flop synchronizer to give `rx_s`. Start event E is the edge at which `rx_s` = 0 and its previous value was 1, while the FSM is in IDLE.
- Configuration is latched at E and held for the whole frame:
  - `data_size` is clamped to 5..MAX_DATA.
  - `bit_period` values below 4 are treated as 4.
- FSM states:
  - IDLE: waits for E.
  - START_CHK: samples at E+floor(bp/2).
    - `rx_s` = 1: false start; return to IDLE with no status change.
    - `rx_s` = 0: go to DATA.
  - DATA: takes N samples, LSB first, spaced bp cycles apart.
  - PARITY: takes one sample; entered only when parity is enabled.
  - STOP: takes one sample, then goes to LOAD.
  - LOAD: one cycle, then return to IDLE.
- Sample k (k=0 is the start bit) is taken at E+floor(bp/2)+k·bp.
- Parity check: even mode requires XOR(data, parity bit) = 0; odd mode requires it to be 1.
- LOAD, with flags updated at the same edge:
  - `framing_error` <= (stop = 0).
  - `parity_error` <= parity failed, when enabled; otherwise 0.
  - Frame with either error: discarded, not written to the FIFO.
  - Good frame, FIFO not full, or full with `data_read` in the same cycle: pushed.
  - Good frame, FIFO full, no `data_read` that cycle: dropped, `overrun_error` set.
- `framing_error` and `parity_error` hold until the next LOAD; a false start does not change them.
- `overrun_error` clears on the first `data_read` that pops an entry after it was set.
- `data_read` while empty: ignored.
- Simultaneous push and pop: the count is unchanged, and head/tail pointers wrap modulo FIFO_DEPTH.
- The FSM can accept a new E on the cycle after LOAD, which allows back-to-back frames.

## Timing
- Reset (async, `n_rst` = 0):
  - FSM in IDLE.
  - Synchronizer flops set to 1.
  - FIFO emptied.
  - All outputs 0: `rx_data`, `data_ready`, `fifo_count`, and all three error flags.
- Asserting reset mid-frame aborts the frame with no FIFO write.
- Latency: with S = stop-sample edge = E+floor(bp/2)+(N+P+1)·bp, where P = 1 when parity is enabled and 0 otherwise:
  - LOAD occurs at S+1.
  - `data_ready`, `fifo_count`, and the error flags are valid after the edge at S+1.
- Pop: `rx_data` shows the next entry, and `fifo_count` decrements, the cycle after `data_read`.
- Raw `serial_in` to E: 2 or 3 cycles, depending on synchronizer alignment.

## Test plan
- bp=10, N=8, no parity, send 0xA5, then 1 stop bit -> `data_ready` rises at E+96, `rx_data`=0xA5, `fifo_count`=1, all error flags 0; pulse `data_read` -> `data_ready` 0 the next cycle.
- N=7, even parity, bp=16, send 0x35 with correct parity, then 0x35 with the parity bit flipped -> first frame queued with `parity_error`=0; second frame discarded with `parity_error`=1, `fifo_count` still 1.
- Stop bit driven 0 on 0x3C -> `framing_error`=1, nothing queued; the next good frame 0x11 clears `framing_error` and is queued.
- FIFO_DEPTH=4: send 5 frames with no reads -> `fifo_count`=4, `overrun_error`=1, head = first byte; one `data_read` -> `overrun_error`=0, `fifo_count`=3; also check that a frame whose LOAD coincides with `data_read` while full is queued without overrun.
- 3-cycle low glitch on `serial_in`, bp=20 -> returns to IDLE, no flag change, `fifo_count` unchanged.
- Reset asserted at mid data bit 4, then released, then a full frame 0x5A sent -> all outputs 0 during reset, and only 0x5A is received afterwards.
